// File: rtl/interrupt_dispatch_ctrl.sv
// interrupt_dispatch_ctrl
// Interrupt scheduler for the microcoded control unit. Holds the IF/IE/IME
// state, picks the highest-priority pending source at instruction
// boundaries and asks the control unit to run the dispatch micro-sequence
// to the matching RST vector. Also sequences HALT sleep/wake, the HALT bug
// indication and the one-instruction delay of EI.

module interrupt_dispatch_ctrl #(
    parameter int         NUM_IRQ       = 5,
    parameter logic [7:0] VECTOR_BASE   = 8'h40,
    parameter logic [7:0] VECTOR_STRIDE = 8'h08
) (
    input  logic               clock,
    input  logic               reset,

    input  logic [NUM_IRQ-1:0] irq_in,

    input  logic               reg_wr_en,
    input  logic               reg_sel,
    input  logic [7:0]         reg_wr_data,
    output logic [7:0]         reg_rd_data,

    input  logic               inst_boundary,
    input  logic               ei_exec,
    input  logic               di_exec,
    input  logic               reti_exec,
    input  logic               halt_exec,

    output logic               dispatch_req,
    output logic [7:0]         dispatch_vec,
    input  logic               dispatch_ack,
    input  logic               dispatch_done,

    output logic               halted,
    output logic               halt_bug,
    output logic               ime
);

    localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HALT
    } state_t;

    state_t             state, state_nxt;

    logic [NUM_IRQ-1:0] if_q, if_nxt;
    logic [NUM_IRQ-1:0] irq_prev;
    logic [NUM_IRQ-1:0] set_mask;
    logic [NUM_IRQ-1:0] pending;
    logic [7:0]         ie_q;

    logic               ime_q, ime_nxt;
    logic               ei_pend_q, ei_pend_nxt;
    logic               ei_cnt_q, ei_cnt_nxt;
    logic               ei_promote;
    logic               ime_eff;

    logic [IDX_W-1:0]   idx_q, idx_nxt, sel_idx;
    logic [7:0]         vec_q, vec_nxt, sel_vec;
    logic               halt_bug_q, halt_bug_nxt;
    logic               ack_take;

    // Rising edges on the source lines; pending is built from registered state only.
    assign set_mask = irq_in & ~irq_prev;
    assign pending  = ie_q[NUM_IRQ-1:0] & if_q;

    // An acknowledge only counts while a request is actually outstanding.
    assign ack_take = dispatch_ack && (state == ST_REQ);

    // The boundary that completes the instruction after EI already sees IME set,
    // so the dispatch can start at that very boundary.
    assign ei_promote = ei_pend_q && ei_cnt_q && inst_boundary && !di_exec;
    assign ime_eff    = ime_q || ei_promote;

    // Lowest set pending bit wins; its vector is formed with 8-bit wrap-around.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave it unassigned and infer a latch.
        sel_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
        sel_vec = VECTOR_BASE + VECTOR_STRIDE * 8'(sel_idx);
    end

    // Register read mux: unused IF bits read back as ones.
    always_comb begin
        reg_rd_data = 8'hFF;
        if (reg_sel) begin
            reg_rd_data = ie_q;
        end else begin
            reg_rd_data[NUM_IRQ-1:0] = if_q;
        end
    end

    // Next IF: software write or acknowledge clear, then new edges always win.
    always_comb begin
        if_nxt = if_q;
        if (reg_wr_en && !reg_sel) begin
            if_nxt = reg_wr_data[NUM_IRQ-1:0];
        end else if (ack_take) begin
            if_nxt[idx_q] = 1'b0;
        end
        if_nxt = if_nxt | set_mask;
    end

    // IME and the EI delay: ack > di > reti > ei for the master enable.
    always_comb begin
        ime_nxt     = ime_q;
        ei_pend_nxt = ei_pend_q;
        ei_cnt_nxt  = ei_cnt_q;

        if (di_exec) begin
            ei_pend_nxt = 1'b0;
            ei_cnt_nxt  = 1'b0;
        end else if (ei_exec) begin
            ei_pend_nxt = 1'b1;
            ei_cnt_nxt  = 1'b0;
        end else if (ei_pend_q && inst_boundary) begin
            if (ei_cnt_q) begin
                ei_pend_nxt = 1'b0;
                ei_cnt_nxt  = 1'b0;
            end else begin
                ei_cnt_nxt  = 1'b1;
            end
        end

        if (ack_take) begin
            ime_nxt = 1'b0;
        end else if (di_exec) begin
            ime_nxt = 1'b0;
        end else if (reti_exec) begin
            ime_nxt = 1'b1;
        end else if (ei_promote) begin
            ime_nxt = 1'b1;
        end
    end

    // Dispatch/halt sequencer: next state, latched source index and vector.
    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx_q;
        vec_nxt      = vec_q;
        halt_bug_nxt = 1'b0;

        case (state)
            ST_IDLE: begin
                // HALT takes precedence over a coincident boundary.
                if (halt_exec) begin
                    if (pending == '0) begin
                        state_nxt = ST_HALT;
                    end else if (!ime_q) begin
                        halt_bug_nxt = 1'b1;
                    end
                end else if (inst_boundary && ime_eff && (pending != '0)) begin
                    state_nxt = ST_REQ;
                    idx_nxt   = sel_idx;
                    vec_nxt   = sel_vec;
                end
            end
            ST_REQ: begin
                if (dispatch_ack) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (dispatch_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_HALT: begin
                // Wake on any enabled pending source, independent of IME.
                if (pending != '0) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State registers; the edge detector tracks irq_in even during reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        irq_prev <= irq_in;
        if (reset) begin
            state      <= ST_IDLE;
            if_q       <= '0;
            ie_q       <= '0;
            ime_q      <= 1'b0;
            ei_pend_q  <= 1'b0;
            ei_cnt_q   <= 1'b0;
            idx_q      <= '0;
            vec_q      <= '0;
            halt_bug_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            if_q       <= if_nxt;
            if (reg_wr_en && reg_sel) begin
                ie_q <= reg_wr_data;
            end
            ime_q      <= ime_nxt;
            ei_pend_q  <= ei_pend_nxt;
            ei_cnt_q   <= ei_cnt_nxt;
            idx_q      <= idx_nxt;
            vec_q      <= vec_nxt;
            halt_bug_q <= halt_bug_nxt;
        end
    end

    assign dispatch_req = (state == ST_REQ);
    assign dispatch_vec = vec_q;
    assign halted       = (state == ST_HALT);
    assign halt_bug     = halt_bug_q;
    assign ime          = ime_q;

endmodule

// File: tb/tb_interrupt_dispatch_ctrl.sv
// Self-checking bench for interrupt_dispatch_ctrl. Expected dispatch vectors
// are pushed into a queue by the stimulus side from an abstract model of
// IF/IE/IME; a monitor pops and compares whenever dispatch_req rises.

module tb_interrupt_dispatch_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] irq_in;
    logic       reg_wr_en;
    logic       reg_sel;
    logic [7:0] reg_wr_data;
    logic [7:0] reg_rd_data;
    logic       inst_boundary;
    logic       ei_exec;
    logic       di_exec;
    logic       reti_exec;
    logic       halt_exec;
    logic       dispatch_req;
    logic [7:0] dispatch_vec;
    logic       dispatch_ack;
    logic       dispatch_done;
    logic       halted;
    logic       halt_bug;
    logic       ime;

    interrupt_dispatch_ctrl dut (
        .clock         (clock),
        .reset         (reset),
        .irq_in        (irq_in),
        .reg_wr_en     (reg_wr_en),
        .reg_sel       (reg_sel),
        .reg_wr_data   (reg_wr_data),
        .reg_rd_data   (reg_rd_data),
        .inst_boundary (inst_boundary),
        .ei_exec       (ei_exec),
        .di_exec       (di_exec),
        .reti_exec     (reti_exec),
        .halt_exec     (halt_exec),
        .dispatch_req  (dispatch_req),
        .dispatch_vec  (dispatch_vec),
        .dispatch_ack  (dispatch_ack),
        .dispatch_done (dispatch_done),
        .halted        (halted),
        .halt_bug      (halt_bug),
        .ime           (ime)
    );

    always #5 clock = ~clock;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];

    // Abstract model: IF/IE contents, master enable, boundaries left until EI takes effect.
    logic [4:0] m_if;
    logic [7:0] m_ie;
    bit         m_ime;
    int         m_ei_left;

    bit         req_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [4:0] p);
        for (int i = 0; i < 5; i++) begin
            if (p[i]) return i;
        end
        return 0;
    endfunction

    function automatic logic [7:0] vec_of(input int i);
        return 8'h40 + 8'(i * 8);
    endfunction

    // Monitor: on every rising dispatch_req compare the vector against the queue.
    always @(posedge clock) begin
        logic [7:0] e;
        #1;
        if (dispatch_req === 1'b1 && !req_prev) begin
            if (exp_q.size() == 0) begin
                check("unexpected_req", 32'(dispatch_req), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("dispatch_vec", 32'(dispatch_vec), 32'(e));
            end
        end
        req_prev = (dispatch_req === 1'b1);
    end

    // Advance to the next falling edge and return all pulse inputs to idle.
    task automatic step();
        @(negedge clock);
        reg_wr_en     = 1'b0;
        inst_boundary = 1'b0;
        ei_exec       = 1'b0;
        di_exec       = 1'b0;
        reti_exec     = 1'b0;
        halt_exec     = 1'b0;
        dispatch_ack  = 1'b0;
        dispatch_done = 1'b0;
    endtask

    task automatic write_reg(input logic sel, input logic [7:0] d);
        reg_wr_en   = 1'b1;
        reg_sel     = sel;
        reg_wr_data = d;
        step();
        if (sel) m_ie = d;
        else     m_if = d[4:0];
    endtask

    task automatic do_reti();
        reti_exec = 1'b1;
        step();
        m_ime = 1'b1;
    endtask

    task automatic do_di();
        di_exec = 1'b1;
        step();
        m_ime     = 1'b0;
        m_ei_left = 0;
    endtask

    task automatic do_ei();
        ei_exec = 1'b1;
        step();
        m_ei_left = 2;
    endtask

    task automatic irq_pulse(input int k);
        irq_in[k] = 1'b1;
        step();
        irq_in[k] = 1'b0;
        step();
        m_if[k] = 1'b1;
    endtask

    task automatic check_regs();
        reg_sel = 1'b0;
        #1;
        check("if_read", 32'(reg_rd_data), 32'({3'b111, m_if}));
        reg_sel = 1'b1;
        #1;
        check("ie_read", 32'(reg_rd_data), 32'(m_ie));
    endtask

    // Acknowledge and complete an outstanding request for source idx.
    task automatic service(input int idx);
        int n = 0;
        while (dispatch_req !== 1'b1 && n < 16) begin
            step();
            n++;
        end
        check("req_seen", 32'(dispatch_req), 32'd1);
        dispatch_ack = 1'b1;
        step();
        m_if[idx] = 1'b0;
        m_ime     = 1'b0;
        check("req_drop_on_ack", 32'(dispatch_req), 32'd0);
        dispatch_done = 1'b1;
        step();
    endtask

    // Issue one instruction boundary; predict from the model whether it dispatches.
    task automatic boundary_expect();
        logic [4:0] p;
        bit         eff;
        bit         go;
        int         idx;
        p   = m_ie[4:0] & m_if;
        eff = m_ime || (m_ei_left == 1);
        go  = eff && (p != 5'd0);
        idx = lowest(p);
        if (go) exp_q.push_back(vec_of(idx));
        if (m_ei_left > 0) begin
            m_ei_left--;
            if (m_ei_left == 0) m_ime = 1'b1;
        end
        inst_boundary = 1'b1;
        step();
        check("ime_after_boundary", 32'(ime), 32'(m_ime));
        if (go) service(idx);
        else    check("no_req", 32'(dispatch_req), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset         = 1'b1;
        irq_in        = '0;
        reg_wr_en     = 1'b0;
        reg_sel       = 1'b0;
        reg_wr_data   = '0;
        inst_boundary = 1'b0;
        ei_exec       = 1'b0;
        di_exec       = 1'b0;
        reti_exec     = 1'b0;
        halt_exec     = 1'b0;
        dispatch_ack  = 1'b0;
        dispatch_done = 1'b0;
        m_if = '0; m_ie = '0; m_ime = 1'b0; m_ei_left = 0;

        // Reset state
        repeat (3) step();
        check("rst_req", 32'(dispatch_req), 32'd0);
        check("rst_vec", 32'(dispatch_vec), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_halt_bug", 32'(halt_bug), 32'd0);
        check("rst_ime", 32'(ime), 32'd0);
        check_regs();
        reset = 1'b0;
        step();

        // Single source, edge-triggered IF, ack clears IF and IME
        write_reg(1'b1, 8'h01);
        do_reti();
        check("ime_after_reti", 32'(ime), 32'd1);
        irq_pulse(0);
        check_regs();
        boundary_expect();
        check_regs();
        check("ime_after_ack", 32'(ime), 32'(m_ime));

        // Priority: bit2 before bit4, then bit4 after RETI
        write_reg(1'b1, 8'h1F);
        write_reg(1'b0, 8'h14);
        do_reti();
        boundary_expect();
        do_reti();
        boundary_expect();
        check_regs();

        // EI delay: dispatch only at the second boundary
        write_reg(1'b1, 8'h01);
        write_reg(1'b0, 8'h01);
        do_ei();
        boundary_expect();
        boundary_expect();
        // DI between the two boundaries cancels the pending EI
        write_reg(1'b0, 8'h01);
        do_ei();
        boundary_expect();
        do_di();
        boundary_expect();
        boundary_expect();
        check("ime_after_di", 32'(ime), 32'd0);

        // HALT with nothing pending sleeps; an enabled edge wakes it, IME=0 -> no dispatch
        write_reg(1'b1, 8'h08);
        write_reg(1'b0, 8'h00);
        halt_exec = 1'b1;
        step();
        check("halted_set", 32'(halted), 32'd1);
        irq_in[3] = 1'b1;
        step();
        m_if[3] = 1'b1;
        check("halted_hold", 32'(halted), 32'd1);
        step();
        check("halted_wake", 32'(halted), 32'd0);
        check("wake_no_req", 32'(dispatch_req), 32'd0);
        irq_in[3] = 1'b0;
        step();
        check("wake_no_req2", 32'(dispatch_req), 32'd0);
        check_regs();

        // HALT bug: IME=0 with an interrupt pending
        write_reg(1'b1, 8'h02);
        write_reg(1'b0, 8'h02);
        halt_exec = 1'b1;
        step();
        check("halt_bug_pulse", 32'(halt_bug), 32'd1);
        check("halt_bug_not_halted", 32'(halted), 32'd0);
        step();
        check("halt_bug_single", 32'(halt_bug), 32'd0);
        check("halt_bug_not_halted2", 32'(halted), 32'd0);
        write_reg(1'b0, 8'h00);

        // Randomised traffic against the model
        for (int it = 0; it < 40; it++) begin
            write_reg(1'b1, 8'($urandom_range(0, 255)));
            write_reg(1'b0, 8'($urandom_range(0, 31)));
            if ($urandom_range(0, 3) == 0) irq_pulse(int'($urandom_range(0, 4)));
            if ($urandom_range(0, 1) == 1) do_reti();
            else                           do_di();
            boundary_expect();
            check_regs();
        end

        // Reset during REQ aborts the dispatch; lines high through reset do not set IF
        write_reg(1'b1, 8'h02);
        write_reg(1'b0, 8'h02);
        do_reti();
        exp_q.push_back(8'h48);
        inst_boundary = 1'b1;
        step();
        check("req_before_reset", 32'(dispatch_req), 32'd1);
        irq_in = 5'h1F;
        reset  = 1'b1;
        step();
        m_if = '0; m_ie = '0; m_ime = 1'b0; m_ei_left = 0;
        check("req_after_reset", 32'(dispatch_req), 32'd0);
        check("ime_after_reset", 32'(ime), 32'd0);
        check_regs();
        step();
        reset = 1'b0;
        step();
        step();
        check_regs();
        check("ime_post_reset", 32'(ime), 32'd0);
        irq_in = '0;
        step();
        check_regs();

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
